// File: rtl/lut_ram_arbiter.sv
// lut_ram_arbiter
// Shares one single-port LUT RAM between the UART-bridge host bus and a
// local user-logic port.
//   clk, rst           : single clock, asynchronous active-high reset
//   host_*             : non-stallable host strobes (buffered in a 2-entry
//                        FIFO), read responses and sticky overflow flag
//   user_*             : held request / combinational grant, read responses
//   ram_*              : RAM drive; ram_rdata_i is valid the cycle after a read
// Contention is resolved round-robin. Read data returns two cycles after
// the grant cycle.
module lut_ram_arbiter #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  input  logic          host_rw_i,
  input  logic          host_valid_i,
  output logic [DW-1:0] host_rdata_o,
  output logic          host_rvalid_o,
  output logic          host_overflow_o,
  input  logic          user_req_i,
  input  logic          user_we_i,
  input  logic [AW-1:0] user_addr_i,
  input  logic [DW-1:0] user_wdata_i,
  output logic          user_gnt_o,
  output logic [DW-1:0] user_rdata_o,
  output logic          user_rvalid_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_USER = 1'b1
  } src_t;

  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  // Host address decode: the 17-bit difference makes addresses below
  // BASE_ADDR wrap to a huge value, so one compare covers both bounds.
  logic [16:0] host_off;
  logic        host_in_range;
  logic        push_req;

  assign host_off      = {1'b0, host_addr_i} - {1'b0, BASE_ADDR};
  assign host_in_range = (host_off < DEPTH17);
  assign push_req      = host_valid_i && host_in_range;

  // 2-entry host FIFO
  logic [AW-1:0] f_addr  [2];
  logic [DW-1:0] f_wdata [2];
  logic          f_rw    [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          full;
  logic          push_ok;
  logic          drop;

  // Arbitration
  src_t last_grant;
  logic host_cand;
  logic user_cand;
  logic grant_host;
  logic grant_user;

  // Response pipeline
  logic s1_vld;
  src_t s1_src;

  // Candidates are masked by rst so every output, including the
  // combinational grant and RAM drive, is 0 while reset is asserted.
  always_comb begin
    host_cand  = (count != 2'd0) && !rst;
    user_cand  = user_req_i && !rst;
    grant_host = host_cand && (!user_cand || (last_grant == SRC_USER));
    grant_user = user_cand && !grant_host;
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    user_gnt_o  = grant_user;
    if (grant_host) begin
      ram_en_o    = 1'b1;
      ram_we_o    = f_rw[rd_ptr];
      ram_addr_o  = f_addr[rd_ptr];
      ram_wdata_o = f_wdata[rd_ptr];
    end else if (grant_user) begin
      ram_en_o    = 1'b1;
      ram_we_o    = user_we_i;
      ram_addr_o  = user_addr_i;
      ram_wdata_o = user_wdata_i;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is only dropped when the host is not granted.
  assign full    = (count == 2'd2);
  assign push_ok = push_req && (!full || grant_host);
  assign drop    = push_req && full && !grant_host;

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      f_addr[wr_ptr]  <= host_off[AW-1:0];
      f_wdata[wr_ptr] <= host_wdata_i;
      f_rw[wr_ptr]    <= host_rw_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count           <= '0;
      host_overflow_o <= 1'b0;
      last_grant      <= SRC_USER;
      s1_vld          <= 1'b0;
      s1_src          <= SRC_HOST;
      host_rvalid_o   <= 1'b0;
      host_rdata_o    <= '0;
      user_rvalid_o   <= 1'b0;
      user_rdata_o    <= '0;
    end else begin
      wr_ptr <= wr_ptr ^ push_ok;
      rd_ptr <= rd_ptr ^ grant_host;
      case ({push_ok, grant_host})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) host_overflow_o <= 1'b1;

      if (grant_host)      last_grant <= SRC_HOST;
      else if (grant_user) last_grant <= SRC_USER;

      // Stage 1 tags a read at the grant cycle; stage 2 captures the RAM's
      // registered data one cycle later and raises the matching strobe.
      s1_vld <= (grant_host || grant_user) && !ram_we_o;
      s1_src <= grant_host ? SRC_HOST : SRC_USER;

      host_rvalid_o <= s1_vld && (s1_src == SRC_HOST);
      user_rvalid_o <= s1_vld && (s1_src == SRC_USER);
      if (s1_vld && (s1_src == SRC_HOST)) host_rdata_o <= ram_rdata_i;
      if (s1_vld && (s1_src == SRC_USER)) user_rdata_o <= ram_rdata_i;
    end
  end

endmodule

// File: doc/lut_ram_arbiter.md
Name: lut_ram_arbiter

Overview:
- Shares one single-port LUT RAM between two requesters: the host bus from the UART bridge and a local user-logic port.
- Host requests are non-stallable pulses, so they are buffered in a 2-entry FIFO.
- Contention between host and user is resolved round-robin.
- Read data returns to the bridge transmit path (host) or to user logic (user) with fixed latency.

Parameters:
- BASE_ADDR, 16'h0000, first host bus address mapped to RAM word 0
- DEPTH, 64, RAM words; host addresses in [BASE_ADDR, BASE_ADDR+DEPTH) are in range
- AW, 6, RAM address width, equals clog2(DEPTH)
- DW, 16, data width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- host_addr_i  in  16  host bus address
- host_wdata_i  in  DW  host write data
- host_rw_i  in  1  1=write, 0=read
- host_valid_i  in  1  one-cycle request strobe, no backpressure
- host_rdata_o  out  DW  host read data
- host_rvalid_o  out  1  one-cycle strobe, host_rdata_o valid
- host_overflow_o  out  1  sticky: a host request was dropped
- user_req_i  in  1  user request, held until granted
- user_we_i  in  1  1=write
- user_addr_i  in  AW  RAM word address
- user_wdata_i  in  DW  user write data
- user_gnt_o  out  1  combinational grant; transfer occurs this cycle
- user_rdata_o  out  DW  user read data
- user_rvalid_o  out  1  one-cycle strobe, user_rdata_o valid
- ram_en_o  out  1  RAM access this cycle
- ram_we_o  out  1  RAM write
- ram_addr_o  out  AW  RAM address
- ram_wdata_o  out  DW  RAM write data
- ram_rdata_i  in  DW  RAM registered read data, valid the cycle after a read access

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; in-flight read responses discarded.
  - All outputs 0; host_overflow_o cleared.
  - last_grant = USER, so the first host/user tie goes to host.
- Host push:
  - Pushes only when host_valid_i=1 and the address is in range.
  - Stored address = (host_addr_i - BASE_ADDR)[AW-1:0]; host_wdata_i and host_rw_i are stored with it.
  - Out-of-range requests are ignored: no push, no response, no overflow.
- FIFO full:
  - Push while full with no pop in the same cycle: request dropped, host_overflow_o=1 until reset.
  - Push and pop in the same cycle while full: push accepted.
  - Pop on empty never occurs.
- Arbitration, evaluated every cycle, at most one grant:
  - Candidates: host (FIFO non-empty) and user (user_req_i=1).
  - Single candidate: that candidate is granted.
  - Both candidates: grant goes to the one not equal to last_grant.
  - last_grant updates on every grant.
  - Host grant pops the FIFO head. User grant drives user_gnt_o=1.
- RAM drive in grant cycle T:
  - ram_en_o=1; ram_we_o, ram_addr_o and ram_wdata_o come from the granted source, combinationally.
  - No grant: all ram_* outputs = 0.
- Read response:
  - ram_rdata_i is sampled at the end of T+1, tagged with the source recorded at T.
  - The matching rvalid strobe is high for exactly one cycle at T+2; rdata is held until the next response.
  - Writes produce no response.
- Uncontended host read latency: host_valid_i in cycle 0 -> RAM access in cycle 1 -> host_rvalid_o in cycle 3.
- Ordering: host responses return in host request order; user responses return in user grant order.
- Back-to-back grants: one access per cycle; response pipeline depth 2, no stalls.
- Read-after-write to the same address in consecutive grants returns the new data, since the RAM writes on grant.

Test Plan:
- Host write 0x1234 to BASE+5, then host read BASE+5 -> RAM write at addr 5; host_rdata_o=0x1234 with host_rvalid_o exactly 3 cycles after the read strobe.
- user_req_i held for a read of addr 7 containing 0xBEEF, no host traffic -> user_gnt_o in the same cycle; user_rvalid_o two cycles later with 0xBEEF.
- Host FIFO holding 2 entries plus user_req_i held continuously -> grant order host, user, host, user; each rvalid goes to the correct side with correct data.
- Three host strobes on consecutive cycles while user wins the tie with last_grant=HOST -> FIFO fills; push-with-pop accepted; host_overflow_o stays 0. Then four strobes with user holding every other grant -> one drop, host_overflow_o=1 and sticky.
- Host read at BASE+DEPTH and at BASE-1 -> no RAM access, no rvalid, no overflow.
- rst asserted in the cycle after a host read grant -> host_rvalid_o never pulses; FIFO empty; all outputs 0 asynchronously; the first tie after release goes to host.
